// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with pending-write scoreboard and clear sweep.
// Optional same-cycle write-to-read forwarding when REGFILE_SB_BYPASS_EN is defined.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr,
    input  logic                clr_req,
    output logic                ready
);
    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [NREGS-1:0] pending_q, pending_d;
    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic             ready_q, ready_d;
    logic             wr_ok, iss_ok;
    logic [AW-1:0]    ra [NRD];
    logic [NRD-1:0]   hit;

    function automatic logic live(input logic [AW-1:0] a);
        return ZERO_REG == 0 || a != '0;
    endfunction

    for (genvar g = 0; g < NRD; g++) begin : g_ra
        assign ra[g] = rd_addr[g*AW +: AW];
    end

    assign ready = ready_q;

    always_comb begin
        wr_ok     = ready_q & wr_en & live(wr_addr);
        iss_ok    = ready_q & issue_en & live(issue_addr);
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        mem_d     = mem_q;
        if (state_q == CLEAR) begin
            mem_d[cnt_q]     = '0;
            pending_d[cnt_q] = 1'b0;
            cnt_d            = cnt_q + 1'b1;
            state_d          = cnt_q == LAST ? READY : CLEAR;
        end else begin
            if (wr_ok) begin
                mem_d[wr_addr]     = wr_data;
                pending_d[wr_addr] = 1'b0;
            end
            // issue after write so a new producer keeps the register pending
            if (iss_ok) pending_d[issue_addr] = 1'b1;
            if (clr_req) begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        end
        ready_d = state_d == READY;
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        hit     = '0;
        for (int k = 0; k < NRD; k++) begin
            hit[k]     = wr_ok && wr_addr == ra[k];
            rd_busy[k] = ready_q & pending_q[ra[k]] & ~hit[k];
`ifdef REGFILE_SB_BYPASS_EN
            rd_data[k*XLEN +: XLEN] = !ready_q || !live(ra[k]) ? '0 : hit[k] ? wr_data : mem_q[ra[k]];
`else
            rd_data[k*XLEN +: XLEN] = !ready_q || !live(ra[k]) ? '0 : mem_q[ra[k]];
`endif
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            pending_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb against an array-based model.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int RAW   = NRD * AW;
`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [RAW-1:0]  rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]  rd_busy;
    logic            wr_en, issue_en, clr_req, ready;
    logic [AW-1:0]   wr_addr, issue_addr;
    logic [XLEN-1:0] wr_data;

    int tests = 0;
    int fails = 0;
    int n;

    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_pend [NREGS];
    bit              m_ready;
    int              m_left;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .clr_req(clr_req), .ready(ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_data(input int k);
        int a = int'(rd_addr[k*AW +: AW]);
        if (!m_ready || a == 0) return '0;
        if (BYP && wr_en && int'(wr_addr) == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int k);
        int a = int'(rd_addr[k*AW +: AW]);
        return m_ready && m_pend[a] && !(wr_en && int'(wr_addr) == a && a != 0);
    endfunction

    task automatic model_check();
        check("ready", ready, m_ready);
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("rd_data%0d", k), rd_data[k*XLEN +: XLEN], exp_data(k));
            check($sformatf("rd_busy%0d", k), rd_busy[k], exp_busy(k));
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_ready = 1'b0;
            m_left  = NREGS;
            for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int i = 0; i < NREGS; i++) begin
                    m_mem[i]  = '0;
                    m_pend[i] = 1'b0;
                end
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
            if (clr_req) begin
                m_ready = 1'b0;
                m_left  = NREGS;
            end
        end
    endtask

    task automatic cyc();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        issue_en = 1'b0;
        clr_req  = 1'b0;
    endtask

    initial begin
        idle();
        rd_addr = '0; wr_addr = '0; issue_addr = '0; wr_data = '0;
        @(posedge clk);
        model_update();
        #1;
        check("reset_ready", ready, 1'b0);
        cyc();
        rst = 1'b0;
        n = 0;
        while (!ready && n < 64) begin cyc(); n++; end
        check("reset_sweep_edges", n, NREGS);

        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        cyc();
        idle();
        rd_addr = {5'd5, 5'd5};
        #1;
        check("r5_port0", rd_data[0 +: XLEN], 32'hDEADBEEF);
        check("r5_port1", rd_data[XLEN +: XLEN], 32'hDEADBEEF);
        cyc();

        wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234; issue_en = 1'b1; issue_addr = 0;
        cyc();
        idle();
        rd_addr = {5'd0, 5'd0};
        #1;
        check("r0_data", rd_data[0 +: XLEN], 0);
        check("r0_busy", rd_busy[0], 1'b0);
        cyc();

        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5A5A5A5; rd_addr = {5'd0, 5'd7};
        #1;
        check("r7_same_cycle", rd_data[0 +: XLEN], BYP ? 32'hA5A5A5A5 : 32'h0);
        cyc();
        idle();
        #1;
        check("r7_next_cycle", rd_data[0 +: XLEN], 32'hA5A5A5A5);
        cyc();

        issue_en = 1'b1; issue_addr = 3;
        cyc();
        idle();
        rd_addr = {5'd3, 5'd3};
        #1;
        check("r3_busy", rd_busy[0], 1'b1);
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'h33;
        #1;
        check("r3_release_comb", rd_busy[0], 1'b0);
        cyc();
        idle();
        #1;
        check("r3_after_wb", rd_busy[1], 1'b0);
        issue_en = 1'b1; issue_addr = 3; wr_en = 1'b1; wr_addr = 3; wr_data = 32'h44;
        cyc();
        idle();
        #1;
        check("r3_issue_wins", rd_busy[0], 1'b1);
        check("r3_issue_wb_data", rd_data[0 +: XLEN], 32'h44);
        cyc();

        for (int r = 1; r <= 4; r++) begin
            wr_en = 1'b1; wr_addr = AW'(r); wr_data = 32'h11111111 * r;
            cyc();
        end
        idle();
        issue_en = 1'b1; issue_addr = 9;
        cyc();
        idle();
        clr_req = 1'b1;
        cyc();
        n = 0;
        while (!ready && n < 64) begin
            wr_en = 1'b1; wr_addr = AW'($urandom); wr_data = $urandom;
            issue_en = 1'b1; issue_addr = AW'($urandom); clr_req = 1'($urandom);
            cyc();
            n++;
        end
        idle();
        check("clr_sweep_edges", n, NREGS);
        for (int r = 1; r <= 4; r++) begin
            rd_addr = {5'd9, AW'(r)};
            #1;
            check($sformatf("clr_r%0d", r), rd_data[0 +: XLEN], 0);
            check("clr_r9_busy", rd_busy[1], 1'b0);
            cyc();
        end

        clr_req = 1'b1;
        cyc();
        idle();
        repeat (9) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n = 0;
        while (!ready && n < 64) begin cyc(); n++; end
        check("rst_mid_sweep_edges", n, NREGS);

        repeat (3000) begin
            rst        = $urandom_range(0, 499) == 0;
            clr_req    = $urandom_range(0, 99) == 0;
            wr_en      = 1'($urandom);
            issue_en   = 1'($urandom);
            wr_addr    = AW'($urandom);
            issue_addr = $urandom_range(0, 3) == 0 ? wr_addr : AW'($urandom);
            wr_data    = $urandom;
            rd_addr    = RAW'($urandom);
            if ($urandom_range(0, 3) == 0) rd_addr[0 +: AW] = wr_addr;
            if ($urandom_range(0, 3) == 0) rd_addr[AW +: AW] = rd_addr[0 +: AW];
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
